// File: rtl/seq_divider_8x4.sv
// rtl/seq_divider_8x4.sv - 8-bit by 4-bit sequential restoring divider
// Optional macro DIV_ZERO_CHECK_EN: zero divisor bypasses RUN and raises div_by_zero.
module seq_divider_8x4 (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] dividend,
    input  logic [3:0] divisor,
    output logic [7:0] quotient,
    output logic [3:0] remainder,
    output logic       busy,
    output logic       done,
    output logic       div_by_zero
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t     state;
    state_t     state_next;
    logic [7:0] dvd_sh;
    logic [3:0] dvs;
    logic [4:0] rem_acc;
    logic [7:0] quo_acc;
    logic [2:0] cnt;
    logic [5:0] trial;
    logic       fit;
    logic [4:0] rem_step;
    logic       zero_skip;

    always_comb begin
        trial    = {rem_acc, dvd_sh[7]};
        fit      = (trial >= {2'b00, dvs});
        rem_step = fit ? 5'(trial - {2'b00, dvs}) : trial[4:0];
    end

`ifdef DIV_ZERO_CHECK_EN
    assign zero_skip = (divisor == 4'd0);
`else
    assign zero_skip = 1'b0;
`endif

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = zero_skip ? DONE : RUN;
            RUN:     if (cnt == 3'd7) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // busy and done are registered copies of the state, so they trail it by one edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            dvd_sh    <= '0;
            dvs       <= '0;
            rem_acc   <= '0;
            quo_acc   <= '0;
            cnt       <= '0;
            quotient  <= '0;
            remainder <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            state <= state_next;
            busy  <= (state == RUN);
            done  <= (state == DONE);
            case (state)
                IDLE: begin
                    if (start) begin
                        dvd_sh  <= dividend;
                        dvs     <= divisor;
                        rem_acc <= '0;
                        quo_acc <= '0;
                        cnt     <= '0;
                        if (zero_skip) begin
                            quotient  <= 8'hFF;
                            remainder <= dividend[3:0];
                        end
                    end
                end
                RUN: begin
                    dvd_sh  <= {dvd_sh[6:0], 1'b0};
                    rem_acc <= rem_step;
                    quo_acc <= {quo_acc[6:0], fit};
                    cnt     <= cnt + 3'd1;
                    if (cnt == 3'd7) begin
                        quotient  <= {quo_acc[6:0], fit};
                        remainder <= rem_step[3:0];
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef DIV_ZERO_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst)
            div_by_zero <= 1'b0;
        else if (state == IDLE && start)
            div_by_zero <= zero_skip;
    end
`else
    assign div_by_zero = 1'b0;
`endif

endmodule

// File: doc/seq_divider_8x4.md
SEQ_DIVIDER_8X4 -- requirements
Module: seq_divider_8x4

Interface
REQ-001 The block SHALL have no parameters; the dividend is fixed at 8 bits and the divisor at 4 bits, as the sequential inverse of the 4x4 multiplier.
REQ-002 clk  input  1  The single clock; all state SHALL update on its rising edge.
REQ-003 rst  input  1  Synchronous active-high reset, sampled on the rising edge of clk.
REQ-004 start  input  1  Request; SHALL be accepted only in IDLE.
REQ-005 dividend  input  8  Unsigned dividend; SHALL be captured on an accepted start.
REQ-006 divisor  input  4  Unsigned divisor; SHALL be captured on an accepted start.
REQ-007 quotient  output  8  Unsigned quotient; SHALL be registered.
REQ-008 remainder  output  4  Unsigned remainder; SHALL be registered.
REQ-009 busy  output  1  High while a division is in progress.
REQ-010 done  output  1  One-cycle pulse marking valid results.
REQ-011 div_by_zero  output  1  Divide-by-zero flag; SHALL be valid together with done.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 In IDLE with start=1, the block SHALL capture its operands and go to RUN with the iteration count cleared to 0.
REQ-014 In IDLE, busy and done SHALL be 0.
REQ-015 RUN SHALL perform one restoring step per cycle, MSB first, over exactly 8 cycles:
- P = {R, next dividend bit}, where R is a 5-bit partial remainder;
- if P >= divisor, then R = P - divisor and the quotient bit is 1;
- otherwise R = P and the quotient bit is 0.
REQ-016 After the 8th RUN cycle the FSM SHALL go to DONE; DONE SHALL last one cycle and then return to IDLE.
REQ-017 Timing: if start is accepted at edge N, then busy SHALL be 1 after edges N+1..N+8, and done SHALL be 1 only after edge N+9.
REQ-018 quotient and remainder SHALL update only on entry to DONE, and SHALL hold until the next DONE or until reset.
REQ-019 For divisor != 0, the results SHALL satisfy quotient*divisor + remainder = dividend, with remainder < divisor.
REQ-020 start asserted in RUN or DONE SHALL be ignored and SHALL NOT be queued.
REQ-021 Changes on dividend or divisor after capture SHALL NOT affect the division in progress.
REQ-022 start held high continuously SHALL begin a new division on each return to IDLE, giving a period of 10 cycles.
REQ-023 Divisor = 0 SHALL produce quotient = 8'hFF and remainder = dividend[3:0].

Reset
REQ-024 With rst=1 at a rising edge, the FSM SHALL enter IDLE and quotient, remainder, busy, done and div_by_zero SHALL all be 0, including mid-RUN.
REQ-025 If rst and start are both 1 at the same edge, rst SHALL win and start SHALL be dropped.
REQ-026 After a reset, the first start SHALL be accepted in the following cycle.

Configuration
REQ-027 With DIV_ZERO_CHECK_EN defined, a captured divisor of 0 SHALL skip RUN and go IDLE -> DONE in one cycle.
REQ-028 In that case, done SHALL be 1 after edge N+1, div_by_zero SHALL be 1, and results SHALL be as in REQ-023.
REQ-029 div_by_zero SHALL be cleared at the next accepted start.
REQ-030 Without DIV_ZERO_CHECK_EN, a divisor of 0 SHALL run the normal 8-cycle algorithm, giving the REQ-023 results naturally, and div_by_zero SHALL be tied to 0.

Verification
REQ-031 dividend=8'd200, divisor=4'd7, start for one cycle -> done after exactly 9 cycles with quotient=28 and remainder=4; busy high for 8 cycles.
REQ-032 dividend=8'd255, divisor=4'd15 -> quotient=17, remainder=0; then 8'd5 / 4'd9 -> quotient=0, remainder=5.
REQ-033 dividend=8'hA7, divisor=0:
- with the macro: done after 1 cycle, div_by_zero=1, quotient=8'hFF, remainder=4'h7;
- without the macro: done after 9 cycles with the same values and div_by_zero=0.
REQ-034 Assert rst in the 4th RUN cycle of 100/3 -> the next cycle is IDLE with all outputs 0; then 100/3 -> quotient=33, remainder=1.
REQ-035 Hold start high and change the operands during RUN -> results match the captured operands; back-to-back done pulses are 10 cycles apart.
REQ-036 Exhaustive 256x15 nonzero-divisor sweep -> REQ-019 holds for every pair.
